// File: rtl/mac_frame_accumulator_if.sv
// Sample-pair input and frame-sum output bundle of the MAC frame accumulator.
// The master side feeds samples and receives sums; the accumulator is the slave.
interface mac_frame_accumulator_if #(
    parameter int DIN_WIDTH = 8,
    parameter int ACC_WIDTH = 19
);
    logic                 in_valid;
    logic                 in_last;
    logic [DIN_WIDTH-1:0] din_a;
    logic [DIN_WIDTH-1:0] din_b;
    logic [ACC_WIDTH-1:0] dout;
    logic [7:0]           dout_width;
    logic                 dout_valid;
    logic                 dout_ovf;
    logic                 dout_forced;

    modport master (
        output in_valid, in_last, din_a, din_b,
        input  dout, dout_width, dout_valid, dout_ovf, dout_forced
    );

    modport slave (
        input  in_valid, in_last, din_a, din_b,
        output dout, dout_width, dout_valid, dout_ovf, dout_forced
    );
endinterface

// File: rtl/mac_frame_accumulator.sv
// Three-stage multiply-accumulate over in_last/MAX_LEN delimited frames with
// saturating sum, sticky overflow and effective-width reporting per frame.
module mac_frame_accumulator #(
    parameter int DIN_WIDTH = 8,
    parameter int ACC_WIDTH = 19,
    parameter int MAX_LEN   = 8,
    parameter int IS_SIGNED = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    mac_frame_accumulator_if.slave    bus
);
    localparam int PW = 2 * DIN_WIDTH;
    localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int NW = $clog2(MAX_LEN + 1);
    localparam int AW = ACC_WIDTH;

    logic [CW-1:0]        cnt;
    logic                 at_max;
    logic                 frame_end;

    logic                 s1_valid, s1_end, s1_forced, s1_first;
    logic [DIN_WIDTH-1:0] s1_a, s1_b;
    logic [NW-1:0]        s1_n;

    logic                 s2_valid, s2_end, s2_forced, s2_first;
    logic [PW-1:0]        s2_prod;
    logic [NW-1:0]        s2_n;

    logic [AW-1:0]        acc;
    logic                 ovf_sticky;

    logic [PW-1:0]        ext_a, ext_b, prod_c;
    logic [AW:0]          prod_ext, acc_base, acc_sum;
    logic [AW-1:0]        acc_sat;
    logic                 ovf_now, ovf_new;
    logic [7:0]           width_c, width_sum;

    // ceil(log2(n)) for n >= 1: position of the highest set bit of n-1, plus one
    function automatic logic [7:0] clog2_n(input logic [NW-1:0] n);
        logic [NW-1:0] m;
        logic [7:0]    r;
        m = n - NW'(1);
        r = '0;
        for (int i = 0; i < NW; i++) begin
            if (m[i]) r = 8'(i + 1);
        end
        return r;
    endfunction

    assign at_max    = (cnt == CW'(MAX_LEN - 1));
    assign frame_end = bus.in_last | at_max;

    always_comb begin
        if (IS_SIGNED != 0) begin
            ext_a = {{DIN_WIDTH{s1_a[DIN_WIDTH-1]}}, s1_a};
            ext_b = {{DIN_WIDTH{s1_b[DIN_WIDTH-1]}}, s1_b};
        end else begin
            ext_a = {{DIN_WIDTH{1'b0}}, s1_a};
            ext_b = {{DIN_WIDTH{1'b0}}, s1_b};
        end
        prod_c = ext_a * ext_b;
    end

    always_comb begin
        if (IS_SIGNED != 0) prod_ext = {{(AW + 1 - PW){s2_prod[PW-1]}}, s2_prod};
        else                prod_ext = {{(AW + 1 - PW){1'b0}}, s2_prod};

        acc_base = s2_first ? '0 : {((IS_SIGNED != 0) && acc[AW-1]), acc};
        acc_sum  = acc_base + prod_ext;

        // The accumulator is one bit wider than the output, so any single step
        // out of range shows up in the top two bits and can be clamped exactly.
        ovf_now = 1'b0;
        acc_sat = acc_sum[AW-1:0];
        if (IS_SIGNED != 0) begin
            if (acc_sum[AW] != acc_sum[AW-1]) begin
                ovf_now = 1'b1;
                acc_sat = acc_sum[AW] ? {1'b1, {(AW - 1){1'b0}}} : {1'b0, {(AW - 1){1'b1}}};
            end
        end else if (acc_sum[AW]) begin
            ovf_now = 1'b1;
            acc_sat = '1;
        end
        ovf_new = ovf_now | (~s2_first & ovf_sticky);

        width_sum = 8'(PW) + clog2_n(s2_n);
        width_c   = (width_sum > 8'(AW)) ? 8'(AW) : width_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            s1_valid        <= 1'b0;
            s1_end          <= 1'b0;
            s1_forced       <= 1'b0;
            s1_first        <= 1'b0;
            s1_a            <= '0;
            s1_b            <= '0;
            s1_n            <= '0;
            s2_valid        <= 1'b0;
            s2_end          <= 1'b0;
            s2_forced       <= 1'b0;
            s2_first        <= 1'b0;
            s2_prod         <= '0;
            s2_n            <= '0;
            acc             <= '0;
            ovf_sticky      <= 1'b0;
            bus.dout        <= '0;
            bus.dout_width  <= '0;
            bus.dout_valid  <= 1'b0;
            bus.dout_ovf    <= 1'b0;
            bus.dout_forced <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a      <= bus.din_a;
                s1_b      <= bus.din_b;
                s1_end    <= frame_end;
                s1_forced <= at_max & ~bus.in_last;
                s1_first  <= (cnt == '0);
                s1_n      <= NW'(cnt) + NW'(1);
                cnt       <= frame_end ? '0 : cnt + CW'(1);
            end

            s2_valid  <= s1_valid;
            s2_end    <= s1_end;
            s2_forced <= s1_forced;
            s2_first  <= s1_first;
            s2_prod   <= prod_c;
            s2_n      <= s1_n;

            bus.dout_valid <= s2_valid & s2_end;
            if (s2_valid) begin
                acc        <= acc_sat;
                ovf_sticky <= ovf_new;
                if (s2_end) begin
                    bus.dout        <= acc_sat;
                    bus.dout_width  <= width_c;
                    bus.dout_ovf    <= ovf_new;
                    bus.dout_forced <= s2_forced;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_frame_accumulator.sv
// Bench for mac_frame_accumulator: three instances (signed/19, signed/17,
// unsigned/19) checked against a frame-level arithmetic model every cycle.
module tb_mac_frame_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_frame_accumulator_if #(.DIN_WIDTH(8), .ACC_WIDTH(19)) bus0 ();
    mac_frame_accumulator_if #(.DIN_WIDTH(8), .ACC_WIDTH(17)) bus1 ();
    mac_frame_accumulator_if #(.DIN_WIDTH(8), .ACC_WIDTH(19)) bus2 ();

    mac_frame_accumulator #(.DIN_WIDTH(8), .ACC_WIDTH(19), .MAX_LEN(8), .IS_SIGNED(1))
        u0 (.clk(clk), .rst(rst), .bus(bus0));
    mac_frame_accumulator #(.DIN_WIDTH(8), .ACC_WIDTH(17), .MAX_LEN(8), .IS_SIGNED(1))
        u1 (.clk(clk), .rst(rst), .bus(bus1));
    mac_frame_accumulator #(.DIN_WIDTH(8), .ACC_WIDTH(19), .MAX_LEN(8), .IS_SIGNED(0))
        u2 (.clk(clk), .rst(rst), .bus(bus2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    typedef struct {
        int     inst;
        int     due;
        longint sum;
        int     width;
        bit     ovf;
        bit     forced;
    } exp_t;

    exp_t   exp_q[$];
    int     aw[3]  = '{19, 17, 19};
    bit     sgn[3] = '{1'b1, 1'b1, 1'b0};
    longint m_acc[3];
    int     m_n[3];
    bit     m_ovf[3];

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int clog2i(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Frame-level model: exact arithmetic with clamping, one entry per closed frame
    task automatic model_sample(input int inst, input int a, input int b, input bit last);
        longint p, lo, hi;
        exp_t   e;
        p = longint'(a) * longint'(b);
        if (sgn[inst]) begin
            hi = (longint'(1) << (aw[inst] - 1)) - 1;
            lo = -(longint'(1) << (aw[inst] - 1));
        end else begin
            hi = (longint'(1) << aw[inst]) - 1;
            lo = 0;
        end
        if (m_n[inst] == 0) begin
            m_acc[inst] = 0;
            m_ovf[inst] = 1'b0;
        end
        m_acc[inst] = m_acc[inst] + p;
        if (m_acc[inst] > hi) begin m_acc[inst] = hi; m_ovf[inst] = 1'b1; end
        if (m_acc[inst] < lo) begin m_acc[inst] = lo; m_ovf[inst] = 1'b1; end
        m_n[inst]++;
        if (last || m_n[inst] == 8) begin
            e.inst   = inst;
            e.due    = cyc + 3;
            e.sum    = m_acc[inst];
            e.width  = (16 + clog2i(m_n[inst]) < aw[inst]) ? 16 + clog2i(m_n[inst]) : aw[inst];
            e.ovf    = m_ovf[inst];
            e.forced = !last;
            exp_q.push_back(e);
            m_n[inst] = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_n[i] = 0;
        for (int j = exp_q.size() - 1; j >= 0; j--)
            if (exp_q[j].due >= cyc + 1) exp_q.delete(j);
    endtask

    task automatic clear_inputs();
        bus0.in_valid = 1'b0; bus0.in_last = 1'b1; bus0.din_a = 8'h00; bus0.din_b = 8'h00;
        bus1.in_valid = 1'b0; bus1.in_last = 1'b1; bus1.din_a = 8'h00; bus1.din_b = 8'h00;
        bus2.in_valid = 1'b0; bus2.in_last = 1'b1; bus2.din_a = 8'h00; bus2.din_b = 8'h00;
    endtask

    task automatic drive(input int inst, input int a, input int b, input bit last);
        case (inst)
            0: begin bus0.in_valid = 1'b1; bus0.in_last = last; bus0.din_a = a[7:0]; bus0.din_b = b[7:0]; end
            1: begin bus1.in_valid = 1'b1; bus1.in_last = last; bus1.din_a = a[7:0]; bus1.din_b = b[7:0]; end
            default: begin bus2.in_valid = 1'b1; bus2.in_last = last; bus2.din_a = a[7:0]; bus2.din_b = b[7:0]; end
        endcase
    endtask

    task automatic send(input int inst, input int a, input int b, input bit last, output int c);
        c = cyc;
        drive(inst, a, b, last);
        model_sample(inst, a, b, last);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_neg(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    logic   g_valid, g_ovf, g_forced;
    longint g_dout;
    int     g_width;

    task automatic read_out(input int inst);
        case (inst)
            0: begin g_valid = bus0.dout_valid; g_dout = longint'(bus0.dout); g_width = int'(bus0.dout_width);
                     g_ovf = bus0.dout_ovf; g_forced = bus0.dout_forced; end
            1: begin g_valid = bus1.dout_valid; g_dout = longint'(bus1.dout); g_width = int'(bus1.dout_width);
                     g_ovf = bus1.dout_ovf; g_forced = bus1.dout_forced; end
            default: begin g_valid = bus2.dout_valid; g_dout = longint'(bus2.dout); g_width = int'(bus2.dout_width);
                     g_ovf = bus2.dout_ovf; g_forced = bus2.dout_forced; end
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                int k;
                k = -1;
                for (int j = 0; j < exp_q.size(); j++)
                    if (exp_q[j].inst == i && exp_q[j].due == cyc) k = j;
                read_out(i);
                if (k >= 0) begin
                    check($sformatf("u%0d_valid", i), longint'(g_valid), 1);
                    check($sformatf("u%0d_dout", i), g_dout,
                          exp_q[k].sum & ((longint'(1) << aw[i]) - 1));
                    check($sformatf("u%0d_width", i), longint'(g_width), longint'(exp_q[k].width));
                    check($sformatf("u%0d_ovf", i), longint'(g_ovf), longint'(exp_q[k].ovf));
                    check($sformatf("u%0d_forced", i), longint'(g_forced), longint'(exp_q[k].forced));
                end else begin
                    check($sformatf("u%0d_idle_valid", i), longint'(g_valid), 0);
                end
            end
            for (int j = exp_q.size() - 1; j >= 0; j--)
                if (exp_q[j].due <= cyc) exp_q.delete(j);
        end
    end

    initial begin
        int c, c1, c2, c8, c10;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin m_n[i] = 0; m_acc[i] = 0; m_ovf[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_dout", longint'(bus0.dout), 0);
        check("rst_width", longint'(bus0.dout_width), 0);
        check("rst_valid", longint'(bus0.dout_valid), 0);
        check("rst_ovf_forced", longint'({bus0.dout_ovf, bus0.dout_forced}), 0);
        chk_en = 1'b1;
        idle(2);

        // 4 x (3*5), closed by in_last: 60, width 16+2
        for (int i = 0; i < 4; i++) send(0, 3, 5, i == 3, c);
        wait_neg(c + 2);
        check("lat_not_early", longint'(bus0.dout_valid), 0);
        wait_neg(c + 3);
        check("t1_valid", longint'(bus0.dout_valid), 1);
        check("t1_dout", longint'(bus0.dout), 60);
        check("t1_width", longint'(bus0.dout_width), 18);
        check("t1_flags", longint'({bus0.dout_ovf, bus0.dout_forced}), 0);
        idle(3);

        // Back-to-back single-sample frames
        send(0, -128, -128, 1'b1, c1);
        send(0, -128, 127, 1'b1, c2);
        wait_neg(c1 + 3);
        check("t2a_dout", longint'(bus0.dout), 16384);
        check("t2a_width", longint'(bus0.dout_width), 16);
        wait_neg(c2 + 3);
        check("t2b_valid", longint'(bus0.dout_valid), 1);
        check("t2b_dout", longint'(bus0.dout), 64'h7C080);
        idle(3);

        // 10 samples of 1*2: forced close after 8, then a 2-sample frame
        c8 = 0;
        for (int i = 0; i < 10; i++) begin
            send(0, 1, 2, i == 9, c);
            if (i == 7) c8 = c;
        end
        c10 = c;
        wait_neg(c8 + 3);
        check("t3a_dout", longint'(bus0.dout), 16);
        check("t3a_width", longint'(bus0.dout_width), 19);
        check("t3a_forced", longint'(bus0.dout_forced), 1);
        wait_neg(c10 + 3);
        check("t3b_dout", longint'(bus0.dout), 4);
        check("t3b_width", longint'(bus0.dout_width), 17);
        check("t3b_forced", longint'(bus0.dout_forced), 0);
        idle(3);

        // ACC_WIDTH=17: positive saturation with in_last on the MAX_LEN-th sample
        for (int i = 0; i < 8; i++) send(1, 127, 127, i == 7, c);
        send(1, 1, 1, 1'b1, c1);
        wait_neg(c + 3);
        check("t4a_dout", longint'(bus1.dout), 65535);
        check("t4a_ovf", longint'(bus1.dout_ovf), 1);
        check("t4a_width", longint'(bus1.dout_width), 17);
        check("t4a_forced", longint'(bus1.dout_forced), 0);
        wait_neg(c1 + 3);
        check("t4b_dout", longint'(bus1.dout), 1);
        check("t4b_ovf", longint'(bus1.dout_ovf), 0);
        idle(2);

        // ACC_WIDTH=17: negative saturation to -65536 (0x10000 in 17 bits)
        for (int i = 0; i < 8; i++) send(1, -128, 127, i == 7, c);
        wait_neg(c + 3);
        check("t4c_dout", longint'(bus1.dout), 65536);
        check("t4c_ovf", longint'(bus1.dout_ovf), 1);
        idle(3);

        // Gaps then reset coinciding with the third sample: partial frame dropped
        send(0, 2, 2, 1'b0, c);
        idle(2);
        send(0, 2, 2, 1'b0, c);
        idle(1);
        drive(0, 2, 2, 1'b0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        check("t5_rst_dout", longint'(bus0.dout), 0);
        check("t5_rst_width", longint'(bus0.dout_width), 0);
        check("t5_rst_valid", longint'(bus0.dout_valid), 0);
        check("t5_rst_flags", longint'({bus0.dout_ovf, bus0.dout_forced}), 0);
        idle(4);
        send(0, 2, 2, 1'b0, c);
        send(0, 2, 2, 1'b1, c);
        wait_neg(c + 3);
        check("t5_dout", longint'(bus0.dout), 8);
        check("t5_width", longint'(bus0.dout_width), 17);
        idle(2);

        // Unsigned instance
        send(2, 255, 255, 1'b0, c);
        send(2, 255, 255, 1'b1, c);
        wait_neg(c + 3);
        check("t6_dout", longint'(bus2.dout), 130050);
        check("t6_width", longint'(bus2.dout_width), 17);
        check("t6_ovf", longint'(bus2.dout_ovf), 0);

        idle(5);
        check("queue_drained", longint'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
